// File: rtl/backing_mem_ctrl.sv
// backing_mem_ctrl: word-addressed backing RAM for the cache, with fixed access latency and a post-reset clear.
// Optional posted-write buffer: BACKING_MEM_POSTED_WRITE_EN. Rev 1.0
`default_nettype none

module backing_mem_ctrl #(
   parameter int DATA_W  = 16,
   parameter int ADDR_W  = 5,
   parameter int LATENCY = 3
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              ready,
   output logic              ack,
   output logic [DATA_W-1:0] rdata,
   output logic              clearing
);

   localparam int         C_DEPTH    = 2**ADDR_W;
   localparam logic [3:0] C_LAT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      S_CLEAR  = 2'd0,
      S_IDLE   = 2'd1,
      S_ACCESS = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_clr_addr;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_we;
   logic [DATA_W-1:0]   r_wdata;
   logic [DATA_W-1:0]   r_rdata;
   logic [3:0]          r_cnt;
   logic                r_ack;
   logic [DATA_W-1:0]   r_mem [0:C_DEPTH-1];

   logic                w_accept;
   logic                w_accept_access;
   logic                w_done;
   logic                w_clr_last;
   logic                w_mem_we;
   logic [ADDR_W-1:0]   w_mem_addr;
   logic [DATA_W-1:0]   w_mem_wdata;

`ifdef BACKING_MEM_POSTED_WRITE_EN
   logic                r_pw_valid;
   logic [ADDR_W-1:0]   r_pw_addr;
   logic [DATA_W-1:0]   r_pw_data;
   logic [3:0]          r_pw_cnt;
   logic                w_pw_accept;
   logic                w_pw_commit;

   // Writes only wait for the buffer; reads may overtake a draining write.
   assign ready           = (r_state == S_IDLE) && (!we || !r_pw_valid);
   assign w_pw_accept     = w_accept && we;
   assign w_accept_access = w_accept && !we;
   assign w_pw_commit     = r_pw_valid && (r_pw_cnt == 4'd0);
`else
   assign ready           = (r_state == S_IDLE);
   assign w_accept_access = w_accept;
`endif

   assign w_accept   = req && ready;
   assign w_done     = (r_state == S_ACCESS) && (r_cnt == 4'd0);
   assign w_clr_last = (r_clr_addr == {ADDR_W{1'b1}});
   assign ack        = r_ack;
   assign rdata      = r_rdata;
   assign clearing   = (r_state == S_CLEAR);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_CLEAR:  if (w_clr_last)      w_state_nxt = S_IDLE;
         S_IDLE:   if (w_accept_access) w_state_nxt = S_ACCESS;
         S_ACCESS: if (w_done)          w_state_nxt = S_IDLE;
         default:                       w_state_nxt = S_CLEAR;
      endcase
   end

   // Single array write port; gated by resetn so an aborted access never commits.
   always_comb begin
      w_mem_we    = 1'b0;
      w_mem_addr  = r_clr_addr;
      w_mem_wdata = '0;
      if (r_state == S_CLEAR) begin
         w_mem_we = resetn;
      end else if (w_done && r_we) begin
         w_mem_we    = resetn;
         w_mem_addr  = r_addr;
         w_mem_wdata = r_wdata;
      end
`ifdef BACKING_MEM_POSTED_WRITE_EN
      else if (w_pw_commit) begin
         w_mem_we    = resetn;
         w_mem_addr  = r_pw_addr;
         w_mem_wdata = r_pw_data;
      end
`endif
   end

   always_ff @(posedge clock) begin
      if (w_mem_we) begin
         r_mem[w_mem_addr] <= w_mem_wdata;
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_clr_addr <= '0;
         r_addr     <= '0;
         r_we       <= 1'b0;
         r_wdata    <= '0;
         r_rdata    <= '0;
         r_cnt      <= 4'd0;
         r_ack      <= 1'b0;
      end else begin
         r_ack <= 1'b0;
         if (r_state == S_CLEAR) begin
            r_clr_addr <= r_clr_addr + 1'b1;
         end
         if (w_accept_access) begin
            r_addr  <= addr;
            r_we    <= we;
            r_wdata <= wdata;
            r_cnt   <= C_LAT_LOAD;
         end
         if (r_state == S_ACCESS) begin
            if (r_cnt == 4'd0) begin
               r_ack <= 1'b1;
               if (!r_we) begin
                  r_rdata <= r_mem[r_addr];
               end
            end else begin
               r_cnt <= r_cnt - 4'd1;
            end
         end
`ifdef BACKING_MEM_POSTED_WRITE_EN
         if (w_pw_accept) begin
            r_ack <= 1'b1;
         end
`endif
      end
   end

`ifdef BACKING_MEM_POSTED_WRITE_EN
   always_ff @(posedge clock) begin
      if (!resetn) begin
         r_pw_valid <= 1'b0;
         r_pw_addr  <= '0;
         r_pw_data  <= '0;
         r_pw_cnt   <= 4'd0;
      end else if (w_pw_accept) begin
         r_pw_valid <= 1'b1;
         r_pw_addr  <= addr;
         r_pw_data  <= wdata;
         r_pw_cnt   <= C_LAT_LOAD;
      end else if (r_pw_valid) begin
         if (r_pw_cnt == 4'd0) begin
            r_pw_valid <= 1'b0;
         end else begin
            r_pw_cnt <= r_pw_cnt - 4'd1;
         end
      end
   end
`endif

endmodule

`default_nettype wire
